divider_param_2nbyn: RTL and testbench

Parametrised sequential restoring divider: 2N-bit dividend by N-bit divisor, giving an N-bit quotient and an N-bit remainder. It is the generalised successor of the fixed 10-by-5 divider. Operands arrive serially on one N-bit bus over three cycles, and results leave serially over two cycles. It adds a busy flag, a clean abort on reset, and an optional signed mode. It sits as a standalone datapath+controller block driven by a sequencer/testbench.

---
 rtl/divider_param_2nbyn.sv | 206 ++++++++++++++++++++
 tb/tb_divider_param_2nbyn.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider_param_2nbyn.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, operands loaded serially.
// Define DIVIDER_SIGNED_EN to add the signed_mode port (two's-complement operands).
module divider_param_2nbyn #(
    parameter int unsigned N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef DIVIDER_SIGNED_EN
    input  logic         signed_mode,
`endif
    input  logic [N-1:0] dataIN,
    output logic         busy,
    output logic         done,
    output logic         OV,
    output logic         DivByZero,
    output logic [N-1:0] dataOUT
);

    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam logic [N-1:0] PosMax = {1'b0, {(N - 1){1'b1}}};
    localparam logic [N-1:0] NegMax = {1'b1, {(N - 1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle, StLdHi, StLdLo, StLdDv, StCheck, StDiv, StOutQ, StOutR
    } state_t;

    state_t           stateQ, stateD;
    logic [2*N-1:0]   dvdQ, dvdD;
    logic [N-1:0]     dvsQ, dvsD;
    logic [N-1:0]     remQ, remD;
    logic [N-1:0]     quoQ, quoD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             signedQ, signedD;
    logic             quoNegQ, quoNegD;
    logic             remNegQ, remNegD;
    logic             ovQ, ovD;
    logic             dbzQ, dbzD;

    logic             busyQ, doneQ, ovOutQ, dbzOutQ;
    logic [N-1:0]     outQ;

    logic             signedSel;
    logic [2*N-1:0]   dvdMag;
    logic [N-1:0]     dvsMag;
    logic [N:0]       shifted, dvsExt, trial;
    logic             ge;
    logic [N-1:0]     remNext, quoNext;

`ifdef DIVIDER_SIGNED_EN
    assign signedSel = signed_mode;
`else
    assign signedSel = 1'b0;
`endif

    // Magnitudes feed the unsigned core; in unsigned mode they are the raw operands.
    assign dvdMag = (signedQ && dvdQ[2*N-1]) ? -dvdQ : dvdQ;
    assign dvsMag = (signedQ && dvsQ[N-1]) ? -dvsQ : dvsQ;

    assign shifted = {remQ, quoQ[N-1]};
    assign dvsExt  = {1'b0, dvsQ};
    assign ge      = shifted >= dvsExt;
    assign trial   = shifted - dvsExt;
    // After a restoring step the partial remainder is below the divisor, so N bits hold it.
    assign remNext = N'(ge ? trial : shifted);
    assign quoNext = {quoQ[N-2:0], ge};

    always_comb begin
        stateD  = stateQ;
        dvdD    = dvdQ;
        dvsD    = dvsQ;
        remD    = remQ;
        quoD    = quoQ;
        cntD    = cntQ;
        signedD = signedQ;
        quoNegD = quoNegQ;
        remNegD = remNegQ;
        ovD     = ovQ;
        dbzD    = dbzQ;
        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    stateD  = StLdHi;
                    signedD = signedSel;
                end
            end
            StLdHi: begin
                dvdD[2*N-1:N] = dataIN;
                stateD        = StLdLo;
            end
            StLdLo: begin
                dvdD[N-1:0] = dataIN;
                stateD      = StLdDv;
            end
            StLdDv: begin
                dvsD   = dataIN;
                stateD = StCheck;
            end
            StCheck: begin
                ovD  = 1'b0;
                dbzD = 1'b0;
                remD = '0;
                quoD = '0;
                cntD = '0;
                if (dvsQ == '0) begin
                    dbzD   = 1'b1;
                    stateD = StOutQ;
                end else if (dvdMag[2*N-1:N] >= dvsMag) begin
                    ovD    = 1'b1;
                    stateD = StOutQ;
                end else begin
                    remD    = dvdMag[2*N-1:N];
                    quoD    = dvdMag[N-1:0];
                    dvsD    = dvsMag;
                    quoNegD = signedQ & (dvdQ[2*N-1] ^ dvsQ[N-1]);
                    remNegD = signedQ & dvdQ[2*N-1];
                    stateD  = StDiv;
                end
            end
            StDiv: begin
                remD = remNext;
                quoD = quoNext;
                cntD = cntQ + 1'b1;
                if (cntQ == CNT_W'(N - 1)) begin
                    stateD = StOutQ;
                    if (signedQ) begin
                        if (quoNext > (quoNegQ ? NegMax : PosMax)) begin
                            ovD  = 1'b1;
                            quoD = '0;
                            remD = '0;
                        end else begin
                            quoD = quoNegQ ? -quoNext : quoNext;
                            remD = remNegQ ? -remNext : remNext;
                        end
                    end
                end
            end
            StOutQ:  stateD = StOutR;
            StOutR:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ  <= StIdle;
            dvdQ    <= '0;
            dvsQ    <= '0;
            remQ    <= '0;
            quoQ    <= '0;
            cntQ    <= '0;
            signedQ <= 1'b0;
            quoNegQ <= 1'b0;
            remNegQ <= 1'b0;
            ovQ     <= 1'b0;
            dbzQ    <= 1'b0;
        end else begin
            stateQ  <= stateD;
            dvdQ    <= dvdD;
            dvsQ    <= dvsD;
            remQ    <= remD;
            quoQ    <= quoD;
            cntQ    <= cntD;
            signedQ <= signedD;
            quoNegQ <= quoNegD;
            remNegQ <= remNegD;
            ovQ     <= ovD;
            dbzQ    <= dbzD;
        end
    end

    // Registered outputs: results appear one edge after the state that selects them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
            outQ    <= '0;
            ovOutQ  <= 1'b0;
            dbzOutQ <= 1'b0;
        end else begin
            busyQ <= (stateD != StIdle) || (stateQ == StOutR);
            doneQ <= (stateQ == StOutQ) || (stateQ == StOutR);
            if (stateQ == StOutQ) begin
                outQ <= quoQ;
            end else if (stateQ == StOutR) begin
                outQ <= remQ;
            end else begin
                outQ <= '0;
            end
            if (stateQ == StIdle && start) begin
                ovOutQ  <= 1'b0;
                dbzOutQ <= 1'b0;
            end else if (stateQ == StOutQ) begin
                ovOutQ  <= ovQ;
                dbzOutQ <= dbzQ;
            end
        end
    end

    assign busy      = busyQ;
    assign done      = doneQ;
    assign dataOUT   = outQ;
    assign OV        = ovOutQ;
    assign DivByZero = dbzOutQ;

endmodule

// File: tb/tb_divider_param_2nbyn.sv
// Bench for divider_param_2nbyn: vector table, hand sequences, random vs arithmetic model.
module tb_divider_param_2nbyn;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dataIN = '0;
`ifdef DIVIDER_SIGNED_EN
    logic         signedMode = 1'b0;
`endif
    logic         busy, done, OV, DivByZero;
    logic [N-1:0] dataOUT;

    int checks = 0;
    int errors = 0;

    divider_param_2nbyn #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef DIVIDER_SIGNED_EN
        .signed_mode(signedMode),
`endif
        .dataIN    (dataIN),
        .busy      (busy),
        .done      (done),
        .OV        (OV),
        .DivByZero (DivByZero),
        .dataOUT   (dataOUT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic [N-1:0] dv;
        logic         sm;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         ov;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int hi, input int lo, input int dv, input int sm,
                                input int q, input int r, input int ov, input int dbz,
                                input int lat);
        vec_t v;
        v.hi = N'(hi); v.lo = N'(lo); v.dv = N'(dv); v.sm = sm[0];
        v.q = N'(q); v.r = N'(r); v.ov = ov[0]; v.dbz = dbz[0]; v.lat = lat;
        return v;
    endfunction

    // Reference: plain integer division on the operand values.
    function automatic vec_t model(input logic [N-1:0] hi, input logic [N-1:0] lo,
                                   input logic [N-1:0] dv, input logic sm);
        vec_t   v;
        longint dd, dvv, magQ, q, r;
        v.hi = hi; v.lo = lo; v.dv = dv; v.sm = sm;
        v.q = '0; v.r = '0; v.ov = 1'b0; v.dbz = 1'b0; v.lat = 5;
        dd  = longint'(hi) * (64'sd1 << N) + longint'(lo);
        dvv = longint'(dv);
        if (sm && hi[N-1]) dd = dd - (64'sd1 << (2 * N));
        if (sm && dv[N-1]) dvv = dvv - (64'sd1 << N);
        if (dvv == 0) begin
            v.dbz = 1'b1;
        end else begin
            magQ = (dd < 0 ? -dd : dd) / (dvv < 0 ? -dvv : dvv);
            if (magQ >= (64'sd1 << N)) begin
                v.ov = 1'b1;
            end else begin
                v.lat = N + 5;
                q = dd / dvv;
                r = dd - q * dvv;
                if (sm && (q > (64'sd1 << (N - 1)) - 1 || q < -(64'sd1 << (N - 1)))) begin
                    v.ov = 1'b1;
                end else begin
                    v.q = N'(q);
                    v.r = N'(r);
                end
            end
        end
        return v;
    endfunction

    // One full transaction; start is edge E0, operands are driven for E1..E3.
    task automatic runTxn(input vec_t v, input string tag, input bit poke);
        int           lat = -1;
        logic [N-1:0] q = '0;
        logic         ov = 1'b0, dbz = 1'b0;
        @(negedge clk);
        start = 1'b1;
        dataIN = N'($urandom);
`ifdef DIVIDER_SIGNED_EN
        signedMode = v.sm;
`endif
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_start"}, busy, 1);
        chk({tag, "_flags_clr"}, {OV, DivByZero}, 0);
        dataIN = v.hi;
        @(negedge clk);
        dataIN = v.lo;
        @(negedge clk);
        dataIN = v.dv;
        @(negedge clk);
        dataIN = N'($urandom);
`ifdef DIVIDER_SIGNED_EN
        signedMode = ~v.sm;
`endif
        for (int e = 4; e < 40; e++) begin
            @(negedge clk);
            if (done) begin
                lat = e;
                q = dataOUT;
                ov = OV;
                dbz = DivByZero;
                break;
            end
            start = poke && (e >= 5) && (e <= 7);
            dataIN = N'($urandom);
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_quot"}, q, v.q);
        chk({tag, "_ov"}, ov, v.ov);
        chk({tag, "_dbz"}, dbz, v.dbz);
        @(negedge clk);
        chk({tag, "_done2"}, done, 1);
        chk({tag, "_busy2"}, busy, 1);
        chk({tag, "_rem"}, dataOUT, v.r);
        @(negedge clk);
        chk({tag, "_idle"}, {busy, done, dataOUT}, 0);
        repeat (2) @(negedge clk);
        chk({tag, "_flags_held"}, {OV, DivByZero}, {v.ov, v.dbz});
        chk({tag, "_still_idle"}, busy, 0);
    endtask

    initial begin
        vec_t v;
        int   doneSeen;

        vecs.push_back(mk(3, 30, 5, 0, 25, 1, 0, 0, 10));
        vecs.push_back(mk(5, 18, 8, 0, 22, 2, 0, 0, 10));
        vecs.push_back(mk(13, 15, 15, 0, 28, 11, 0, 0, 10));
        vecs.push_back(mk(13, 14, 11, 0, 0, 0, 1, 0, 5));
        vecs.push_back(mk(5, 14, 0, 0, 0, 0, 0, 1, 5));
        vecs.push_back(mk(0, 0, 7, 0, 0, 0, 0, 0, 10));
        vecs.push_back(mk(30, 31, 31, 0, 31, 30, 0, 0, 10));
        vecs.push_back(mk(31, 31, 31, 0, 0, 0, 1, 0, 5));
        vecs.push_back(mk(31, 18, 3, 0, 0, 0, 1, 0, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5));
`ifdef DIVIDER_SIGNED_EN
        vecs.push_back(mk(31, 18, 3, 1, 28, 30, 0, 0, 10));
        vecs.push_back(mk(16, 0, 1, 1, 0, 0, 1, 0, 5));
        vecs.push_back(mk(31, 16, 1, 1, 16, 0, 0, 0, 10));
        vecs.push_back(mk(0, 16, 1, 1, 0, 0, 1, 0, 10));
        vecs.push_back(mk(0, 7, 30, 1, 29, 1, 0, 0, 10));
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, OV, DivByZero, dataOUT}, 0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) runTxn(vecs[i], $sformatf("vec%0d", i), 1'b0);

        // Start pulses while busy must not disturb the transaction.
        runTxn(mk(13, 15, 15, 0, 28, 11, 0, 0, 10), "poke", 1'b1);

        // Reset in the middle of DIV.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dataIN = 5'd3;
        @(negedge clk);
        dataIN = 5'd30;
        @(negedge clk);
        dataIN = 5'd5;
        repeat (4) @(negedge clk);
        chk("rst_busy_before", busy, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("rst_mid_div", {busy, done, OV, DivByZero, dataOUT}, 0);
        @(negedge clk);
        rst = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        chk("rst_no_done", doneSeen, 0);
        runTxn(mk(5, 18, 8, 0, 22, 2, 0, 0, 10), "after_rst", 1'b0);

        // Randomised transactions against the arithmetic model.
        for (int i = 0; i < 120; i++) begin
            logic [N-1:0] hi, lo, dv;
            logic         sm;
            dv = N'($urandom);
            if ($urandom_range(0, 15) == 0) dv = '0;
            hi = N'($urandom);
            if ($urandom_range(0, 3) != 0 && dv != '0) hi = N'($urandom_range(0, 31) % dv);
            lo = N'($urandom);
`ifdef DIVIDER_SIGNED_EN
            sm = 1'($urandom);
`else
            sm = 1'b0;
`endif
            v = model(hi, lo, dv, sm);
            runTxn(v, $sformatf("rnd%0d", i), i % 7 == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
